// File: rtl/vedic_pkg.sv
// ---------------------------------------------------------------------------
// vedic_pkg
// Shared helpers for the Vedic multiplier blocks.
//   clog2   : ceiling log2 of a positive integer (constant function)
//   is_pow2 : true when n is a positive power of two; used to reject bad widths
// Widths are derived locally from each module's own parameters; nothing global.
// ---------------------------------------------------------------------------
package vedic_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/vedic_nxn_comb.sv
// ---------------------------------------------------------------------------
// vedic_nxn_comb
// Combinational, recursive N x N unsigned Vedic (Urdhva-Tiryagbhyam) multiplier.
//   N = 2 : AND terms combined with two half adders.
//   N > 2 : four N/2 x N/2 sub-products combined by shift-add.
// Ports:
//   a [N-1:0]   multiplicand
//   b [N-1:0]   multiplier
//   p [2N-1:0]  unsigned product a*b
// N must be a power of two >= 2 (checked by the instantiating block).
// ---------------------------------------------------------------------------
module vedic_nxn_comb #(
    parameter int N = 2
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    generate
        if (N == 2) begin : g_base
            logic t10;
            logic t01;
            logic t11;
            logic c1;

            assign t10 = a[1] & b[0];
            assign t01 = a[0] & b[1];
            assign t11 = a[1] & b[1];

            // Column 1 half adder, then column 2 half adder absorbs its carry.
            assign p[0] = a[0] & b[0];
            assign p[1] = t10 ^ t01;
            assign c1   = t10 & t01;
            assign p[2] = t11 ^ c1;
            assign p[3] = t11 & c1;
        end else begin : g_rec
            localparam int H = N / 2;

            logic [N-1:0] qll;
            logic [N-1:0] qhl;
            logic [N-1:0] qlh;
            logic [N-1:0] qhh;

            vedic_nxn_comb #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(qll));
            vedic_nxn_comb #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(qhl));
            vedic_nxn_comb #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(qlh));
            vedic_nxn_comb #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(qhh));

            // Cross terms sit H places up, the high term N places up; never overflows 2N bits.
            assign p = {{N{1'b0}}, qll}
                     + ({{N{1'b0}}, qhl} << H)
                     + ({{N{1'b0}}, qlh} << H)
                     + {qhh, {N{1'b0}}};
        end
    endgenerate

endmodule

// File: rtl/vedic_mul_pipe.sv
// ---------------------------------------------------------------------------
// vedic_mul_pipe
// Two-stage pipelined WIDTH x WIDTH Vedic multiplier, unsigned or signed,
// with valid/ready handshakes on both sides (2-entry FIFO behaviour).
//   S1: sign/magnitude split and four H x H quadrant products (H = WIDTH/2).
//   S2: shift-add of the quadrants, optional negation, registered output.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid / in_ready    operand handshake
//   in_signed              1 = two's-complement operands (only if SIGNED_EN)
//   in_a, in_b [WIDTH]     operands
//   out_valid / out_ready  product handshake
//   out_p [2*WIDTH]        product
// ---------------------------------------------------------------------------
module vedic_mul_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p
);

    localparam int H = WIDTH / 2;

    generate
        if (!is_pow2(WIDTH) || (WIDTH < 4)) begin : g_bad_width
            $error("vedic_mul_pipe: WIDTH must be a power of two and >= 4");
        end
    endgenerate

    logic             sgn;
    logic             neg_c;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] qll_c;
    logic [WIDTH-1:0] qhl_c;
    logic [WIDTH-1:0] qlh_c;
    logic [WIDTH-1:0] qhh_c;

    logic             s1_valid;
    logic             neg_r;
    logic [WIDTH-1:0] qll_r;
    logic [WIDTH-1:0] qhl_r;
    logic [WIDTH-1:0] qlh_r;
    logic [WIDTH-1:0] qhh_r;

    logic               s1_load;
    logic               s2_load;
    logic [2*WIDTH-1:0] sum;
    logic [2*WIDTH-1:0] p_next;

    assign sgn   = SIGNED_EN ? in_signed : 1'b0;
    assign neg_c = sgn & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);

    // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is still
    // the correct unsigned magnitude in WIDTH bits.
    assign mag_a = (sgn && in_a[WIDTH-1]) ? (~in_a + WIDTH'(1)) : in_a;
    assign mag_b = (sgn && in_b[WIDTH-1]) ? (~in_b + WIDTH'(1)) : in_b;

    vedic_nxn_comb #(.N(H)) u_qll (.a(mag_a[H-1:0]),     .b(mag_b[H-1:0]),     .p(qll_c));
    vedic_nxn_comb #(.N(H)) u_qhl (.a(mag_a[WIDTH-1:H]), .b(mag_b[H-1:0]),     .p(qhl_c));
    vedic_nxn_comb #(.N(H)) u_qlh (.a(mag_a[H-1:0]),     .b(mag_b[WIDTH-1:H]), .p(qlh_c));
    vedic_nxn_comb #(.N(H)) u_qhh (.a(mag_a[WIDTH-1:H]), .b(mag_b[WIDTH-1:H]), .p(qhh_c));

    // S2 takes S1 whenever the output register is empty or being drained;
    // S1 can accept whenever it is empty or moving into S2 this cycle.
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || !out_valid || out_ready;
    assign s1_load  = in_valid && in_ready;

    assign sum = {{WIDTH{1'b0}}, qll_r}
               + ({{WIDTH{1'b0}}, qhl_r} << H)
               + ({{WIDTH{1'b0}}, qlh_r} << H)
               + {qhh_r, {WIDTH{1'b0}}};

    // A zero magnitude negates to zero, so no special case for signed zero.
    assign p_next = neg_r ? (~sum + (2*WIDTH)'(1)) : sum;

    // Stage 1: capture quadrant products and sign with their valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            neg_r    <= 1'b0;
            qll_r    <= '0;
            qhl_r    <= '0;
            qlh_r    <= '0;
            qhh_r    <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                neg_r    <= neg_c;
                qll_r    <= qll_c;
                qhl_r    <= qhl_c;
                qlh_r    <= qlh_c;
                qhh_r    <= qhh_c;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: hold the product while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_p     <= '0;
        end else begin
            if (s2_load) begin
                out_valid <= 1'b1;
                out_p     <= p_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// ---------------------------------------------------------------------------
// tb_vedic_mul_pipe
// Self-checking bench for vedic_mul_pipe at WIDTH=8, SIGNED_EN=1.
// Expected products come from plain integer multiplication held in a queue
// of accepted transactions; outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_vedic_mul_pipe;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic           in_signed;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;

    int             total = 0;
    int             bad   = 0;
    int             delivered = 0;
    logic [2*W-1:0] expq[$];

    vedic_mul_pipe #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: ordinary integer product in the selected mode, truncated to 2W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint r;
        if (s) r = longint'($signed(a)) * longint'($signed(b));
        else   r = longint'(a) * longint'(b);
        return r[2*W-1:0];
    endfunction

    task automatic applyStimulus(input logic v, input logic s, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
        in_valid  = v;
        in_signed = s;
        in_a      = a;
        in_b      = b;
    endtask

    // Called at the falling edge: checks the presented product against the
    // oldest outstanding transaction, then records any accept at the next edge.
    task automatic checkOutput();
        if (out_valid) begin
            if (expq.size() == 0) begin
                chk("spurious_out_valid", 64'(out_valid), 64'(0));
            end else begin
                chk("out_p", 64'(out_p), 64'(expq[0]));
                if (out_ready) begin
                    void'(expq.pop_front());
                    delivered++;
                end
            end
        end
        if (in_valid && in_ready) expq.push_back(ref_mul(in_signed, in_a, in_b));
    endtask

    task automatic cycle();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic latency_test(input string tag, input logic s, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [2*W-1:0] exp);
        applyStimulus(1'b1, s, a, b);
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        checkOutput();
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk({tag, "_early"}, 64'(out_valid), 64'(0));
        checkOutput();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_p"}, 64'(out_p), 64'(exp));
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int             d0;
        int             idx;
        logic           bs[3];
        logic [W-1:0]   ba[3];
        logic [W-1:0]   bb[3];
        logic           rs;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;

        rst       = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0);
        #3;
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_out_p", 64'(out_p), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed products with exact 2-cycle latency.
        latency_test("u_ff_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        latency_test("u_0d_0b", 1'b0, 8'h0D, 8'h0B, 16'h008F);
        latency_test("s_80_80", 1'b1, 8'h80, 8'h80, 16'h4000);
        latency_test("s_ff_01", 1'b1, 8'hFF, 8'h01, 16'hFFFF);
        latency_test("s_00_80", 1'b1, 8'h00, 8'h80, 16'h0000);
        latency_test("u_80_ff", 1'b0, 8'h80, 8'hFF, 16'h7F80);
        cycle();

        // Streaming: back-to-back random pairs, mixed modes.
        out_ready = 1'b1;
        d0 = delivered;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
            @(negedge clk);
            if (i == 0 || i == 128 || i == 255) chk("stream_in_ready", 64'(in_ready), 64'(1));
            checkOutput();
            @(posedge clk);
            #1;
        end
        chk("stream_rate", 64'(delivered - d0), 64'(254));
        applyStimulus(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 6; i++) cycle();
        chk("stream_count", 64'(delivered - d0), 64'(256));
        chk("stream_drained", 64'(expq.size()), 64'(0));

        // Backpressure: three pairs offered against a stalled consumer.
        for (int i = 0; i < 3; i++) begin
            bs[i] = 1'($urandom);
            ba[i] = 8'($urandom);
            bb[i] = 8'($urandom);
        end
        out_ready = 1'b0;
        d0  = delivered;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, bs[idx], ba[idx], bb[idx]);
            @(negedge clk);
            if (in_valid && in_ready) begin
                checkOutput();
                idx++;
            end else begin
                checkOutput();
            end
            @(posedge clk);
            #1;
        end
        chk("bp_accepts", 64'(idx), 64'(2));
        @(negedge clk);
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_out_valid", 64'(out_valid), 64'(1));
        chk("bp_hold_first", 64'(out_p), 64'(ref_mul(bs[0], ba[0], bb[0])));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int c = 0; c < 12 && (idx < 3 || expq.size() != 0); c++) begin
            if (idx < 3) applyStimulus(1'b1, bs[idx], ba[idx], bb[idx]);
            else         applyStimulus(1'b0, 1'b0, '0, '0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                checkOutput();
                idx++;
            end else begin
                checkOutput();
            end
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 1'b0, '0, '0);
        chk("bp_delivered", 64'(delivered - d0), 64'(3));
        chk("bp_drained", 64'(expq.size()), 64'(0));

        // Asynchronous reset with two products in flight.
        applyStimulus(1'b1, 1'b0, 8'h12, 8'h34);
        cycle();
        applyStimulus(1'b1, 1'b1, 8'h9A, 8'h05);
        cycle();
        applyStimulus(1'b0, 1'b0, '0, '0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        expq.delete();
        @(posedge clk);
        #1;
        chk("arst_hold_out_valid", 64'(out_valid), 64'(0));
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rs = 1'($urandom);
        ra = 8'($urandom);
        rb = 8'($urandom);
        latency_test("post_reset", rs, ra, rb, ref_mul(rs, ra, rb));
        for (int i = 0; i < 4; i++) cycle();
        chk("post_reset_idle", 64'(out_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
